// File: rtl/hwag_pkg.sv
// hwag_pkg: shared defaults for the hwag host register bank.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package hwag_pkg;

  localparam int HWAG_DATA_W     = 16;
  localparam int HWAG_ADDR_W     = 8;
  localparam int HWAG_NREGS      = 8;
  localparam int SYNC_STAGES_MIN = 2;

  // Register index for the default bank size.
  typedef logic [$clog2(HWAG_NREGS)-1:0] reg_idx_t;

endpackage

// File: rtl/hwag_sync.sv
// hwag_sync: WIDTH-bit, STAGES-deep flop-chain synchroniser.
// Latency: STAGES clk edges from d to q.
// Backpressure: none; samples every cycle.
module hwag_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_chain [STAGES];

  // Shift the input through the chain; reset clears every stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) r_chain[i] <= '0;
    end else begin
      r_chain[0] <= d;
      for (int i = 1; i < STAGES; i++) r_chain[i] <= r_chain[i-1];
    end
  end

  assign q = r_chain[STAGES-1];

endmodule

// File: rtl/hwag_ssram_regs.sv
// hwag_ssram_regs: host SSRAM-style bus to hwag configuration register bank.
// Latency: host pin change -> register update / read data = SYNC_STAGES+1 clk edges.
// Backpressure: none; host must hold addr/data >= SYNC_STAGES+1 cycles per access.
module hwag_ssram_regs
  import hwag_pkg::*;
#(
  parameter int               DATA_W      = HWAG_DATA_W,
  parameter int               ADDR_W      = HWAG_ADDR_W,
  parameter int               NREGS       = HWAG_NREGS,
  parameter logic [NREGS-1:0] RO_MASK     = '0,
  parameter int               SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ssram_we,
  input  logic                    ssram_re,
  input  logic [ADDR_W-1:0]       ssram_addr,
  inout  wire  [DATA_W-1:0]       ssram_data,
  input  logic [NREGS*DATA_W-1:0] sts_d,
  output logic [NREGS*DATA_W-1:0] reg_q,
  output logic [NREGS-1:0]        reg_wr_stb,
  output logic                    err,
  input  logic                    err_clr
);

  localparam int SYNC_W = 2 + ADDR_W + DATA_W;
  localparam int IDX_W  = (NREGS > 1) ? $clog2(NREGS) : 1;
  // A chain shorter than two flops is not a synchroniser; clamp it.
  localparam int STAGES = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;
  localparam logic [ADDR_W:0] LP_NREGS = (ADDR_W+1)'(NREGS);

  logic [SYNC_W-1:0]             w_sync_q;
  logic                          w_we_s, w_re_s;
  logic [ADDR_W-1:0]             w_addr_s;
  logic [DATA_W-1:0]             w_data_s;
  logic                          w_in_range, w_ro, w_wr_only, w_rd_only;
  logic                          w_commit, w_wr_ok, w_err_set;
  logic [IDX_W-1:0]              w_idx;
  logic [NREGS-1:0]              w_wr_sel;
  logic [DATA_W-1:0]             w_rd_val;

  logic                          r_we_prev;
  logic [ADDR_W-1:0]             r_addr_prev;
  logic [NREGS-1:0][DATA_W-1:0]  r_regs;
  logic [NREGS-1:0]              r_wr_stb;
  logic [DATA_W-1:0]             r_rd_q;
  logic                          r_oe, r_err;

  hwag_sync #(.WIDTH(SYNC_W), .STAGES(STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({ssram_we, ssram_re, ssram_addr, ssram_data}),
    .q   (w_sync_q)
  );

  assign {w_we_s, w_re_s, w_addr_s, w_data_s} = w_sync_q;

  // Full-width compare so aliases above NREGS are rejected, not folded.
  assign w_in_range = ({1'b0, w_addr_s} < LP_NREGS);
  assign w_idx      = w_addr_s[IDX_W-1:0];
  assign w_ro       = w_in_range & RO_MASK[w_idx];
  assign w_wr_only  = w_we_s & ~w_re_s;
  assign w_rd_only  = w_re_s & ~w_we_s;
  // A held we sweeping addresses writes each new address once.
  assign w_commit   = w_wr_only & (~r_we_prev | (w_addr_s != r_addr_prev));
  assign w_wr_ok    = w_commit & w_in_range & ~w_ro;
  assign w_err_set  = (w_commit & ~w_wr_ok) | (w_rd_only & ~w_in_range) | (w_we_s & w_re_s);

  // One-hot write select for the committing register.
  always_comb begin
    w_wr_sel = '0;
    if (w_wr_ok) w_wr_sel[w_idx] = 1'b1;
  end

  // Read mux: status input for read-only slots, stored value otherwise.
  always_comb begin
    w_rd_val = '0;
    if (w_in_range) w_rd_val = w_ro ? sts_d[w_idx*DATA_W +: DATA_W] : r_regs[w_idx];
  end

  // Previous-cycle strobe/address for edge and address-change detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we_prev   <= 1'b0;
      r_addr_prev <= '0;
    end else begin
      r_we_prev   <= w_we_s;
      r_addr_prev <= w_addr_s;
    end
  end

  // Register array and write strobes; strobe aligns with the new value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_regs   <= '0;
      r_wr_stb <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (w_wr_sel[i]) r_regs[i] <= w_data_s;
      end
      r_wr_stb <= w_wr_sel;
    end
  end

  // Read data tracks the address while reading; output enable is registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_q <= '0;
      r_oe   <= 1'b0;
    end else begin
      if (w_rd_only) r_rd_q <= w_rd_val;
      r_oe <= w_rd_only;
    end
  end

  // Sticky error flag; a new error wins over a clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_err <= 1'b0;
    else if (w_err_set) r_err <= 1'b1;
    else if (err_clr)   r_err <= 1'b0;
  end

  assign reg_q      = r_regs;
  assign reg_wr_stb = r_wr_stb;
  assign err        = r_err;
  assign ssram_data = r_oe ? r_rd_q : 'z;

endmodule
